lcd_bus_ctrl: RTL and testbench

LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

---
 rtl/lcd_bus_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_lcd_bus_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl
// Drives an HD44780-style character LCD in 8-bit write-only mode.
// After reset the block waits for the panel's power-on time. It then
// sends the four init commands (function set, display on, clear, entry
// mode) and raises init_done. From then on it serves one character write
// per request: an address command (DDRAM set) followed by the data byte.
// Each bus byte runs through SETUP -> ENABLE -> HOLD -> WAIT phases, and
// every phase length comes from a parameter.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   rq_lcd            : write request level, held until ack_lcd
//   lcd_row           : 0 = top line, 1 = bottom line
//   lcd_column[5:0]   : column 0..39; values >= 40 are acknowledged but dropped
//   lcd_char[7:0]     : character code to write
//   ack_lcd           : one-cycle pulse when a request is finished
//   init_done         : high from the first entry into IDLE until reset
//   lcd_rs/rw/e/data  : HD44780 bus (rw tied low, write only)
module lcd_bus_ctrl #(
  parameter int P_PWR  = 750000,
  parameter int P_AS   = 2,
  parameter int P_EW   = 12,
  parameter int P_H    = 2,
  parameter int P_EXEC = 2000,
  parameter int P_CLR  = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rq_lcd,
  input  logic       lcd_row,
  input  logic [5:0] lcd_column,
  input  logic [7:0] lcd_char,
  output logic       ack_lcd,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int CW = 20;

  // Each phase loads N-1 on entry and advances when the counter reads 0,
  // so the phase lasts exactly N cycles. The power-on count is one less
  // because the first cycle after reset release is spent arming the counter.
  localparam logic [CW-1:0] C_PWR  = (P_PWR > 1) ? CW'(P_PWR - 2) : '0;
  localparam logic [CW-1:0] C_AS   = CW'(P_AS - 1);
  localparam logic [CW-1:0] C_EW   = CW'(P_EW - 1);
  localparam logic [CW-1:0] C_H    = CW'(P_H - 1);
  localparam logic [CW-1:0] C_EXEC = CW'(P_EXEC - 1);
  localparam logic [CW-1:0] C_CLR  = CW'(P_CLR - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_SET_ADDR,
    ST_WR_CHAR,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_ENABLE,
    PH_HOLD,
    PH_WAIT
  } phase_t;

  state_t          st_q, st_d;
  phase_t          ph_q, ph_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            armed_q, armed_d;
  logic [7:0]      char_q, char_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            clr_byte;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  // The clear-display command needs the long execution wait.
  assign clr_byte = (st_q == ST_INIT) && (idx_q == 2'd2);

  always_comb begin
    st_d    = st_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    char_d  = char_q;
    e_d     = e_q;
    rs_d    = rs_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    done_d  = done_q;

    unique case (st_q)
      ST_PWR_WAIT: begin
        if (!armed_q) begin
          armed_d = 1'b1;
          cnt_d   = C_PWR;
        end else if (cnt_q == '0) begin
          st_d   = ST_INIT;
          idx_d  = 2'd0;
          data_d = init_cmd(2'd0);
          rs_d   = 1'b0;
          ph_d   = PH_SETUP;
          cnt_d  = C_AS;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end

      // All three byte-writing states share the same phase sequencer and
      // differ only in what happens once the execution wait is over.
      ST_INIT, ST_SET_ADDR, ST_WR_CHAR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - C_ONE;
        end else begin
          unique case (ph_q)
            PH_SETUP: begin
              e_d   = 1'b1;
              ph_d  = PH_ENABLE;
              cnt_d = C_EW;
            end
            PH_ENABLE: begin
              e_d   = 1'b0;
              ph_d  = PH_HOLD;
              cnt_d = C_H;
            end
            PH_HOLD: begin
              ph_d  = PH_WAIT;
              cnt_d = clr_byte ? C_CLR : C_EXEC;
            end
            PH_WAIT: begin
              ph_d  = PH_SETUP;
              cnt_d = C_AS;
              if (st_q == ST_INIT) begin
                if (idx_q == 2'd3) begin
                  st_d   = ST_IDLE;
                  done_d = 1'b1;
                end else begin
                  idx_d  = idx_q + 2'd1;
                  data_d = init_cmd(idx_q + 2'd1);
                  rs_d   = 1'b0;
                end
              end else if (st_q == ST_SET_ADDR) begin
                st_d   = ST_WR_CHAR;
                data_d = char_q;
                rs_d   = 1'b1;
              end else begin
                st_d  = ST_ACK;
                ack_d = 1'b1;
              end
            end
            default: ph_d = PH_SETUP;
          endcase
        end
      end

      // Row and column are folded into the address byte as they are
      // accepted; the character is kept for the second byte.
      ST_IDLE: begin
        if (rq_lcd) begin
          char_d = lcd_char;
          if (lcd_column >= 6'd40) begin
            st_d  = ST_ACK;
            ack_d = 1'b1;
          end else begin
            st_d   = ST_SET_ADDR;
            data_d = {1'b1, lcd_row, lcd_column};
            rs_d   = 1'b0;
            ph_d   = PH_SETUP;
            cnt_d  = C_AS;
          end
        end
      end

      ST_ACK: begin
        st_d = ST_IDLE;
      end

      default: st_d = ST_PWR_WAIT;
    endcase
  end

  // Bus outputs are registered, so an asserted reset drops E immediately
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_PWR_WAIT;
      ph_q    <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      armed_q <= 1'b0;
      char_q  <= 8'h00;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      char_q  <= char_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign lcd_e     = e_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = data_q;
  assign ack_lcd   = ack_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl
// Directed bench for lcd_bus_ctrl using shortened wait parameters. A
// monitor records every E pulse (data, RS, width, edge times), and the
// main sequence compares those records against hand-computed bytes and
// cycle distances.
module tb_lcd_bus_ctrl;

  localparam int P_PWR  = 10;
  localparam int P_AS   = 2;
  localparam int P_EW   = 12;
  localparam int P_H    = 2;
  localparam int P_EXEC = 5;
  localparam int P_CLR  = 20;

  logic       clk;
  logic       rst_n;
  logic       rq_lcd;
  logic       lcd_row;
  logic [5:0] lcd_column;
  logic [7:0] lcd_char;
  logic       ack_lcd;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  lcd_bus_ctrl #(
    .P_PWR (P_PWR),
    .P_AS  (P_AS),
    .P_EW  (P_EW),
    .P_H   (P_H),
    .P_EXEC(P_EXEC),
    .P_CLR (P_CLR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rq_lcd    (rq_lcd),
    .lcd_row   (lcd_row),
    .lcd_column(lcd_column),
    .lcd_char  (lcd_char),
    .ack_lcd   (ack_lcd),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  int cyc       = 0;
  int ack_count = 0;
  int ack_long  = 0;
  int stab_err  = 0;

  logic [7:0] q_data[$];
  logic       q_rs[$];
  int         q_width[$];
  int         q_rise[$];
  int         q_fall[$];

  logic [7:0] init_bytes[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus monitor: samples on the falling edge, logs each E pulse and checks
  // that RS/data hold still from setup through the first hold sample.
  initial begin
    logic       e_prev;
    logic       ack_prev;
    logic [7:0] cur_data;
    logic [7:0] prev_data;
    logic       cur_rs;
    logic       prev_rs;
    int         width;
    e_prev    = 1'b0;
    ack_prev  = 1'b0;
    cur_data  = 8'h00;
    prev_data = 8'h00;
    cur_rs    = 1'b0;
    prev_rs   = 1'b0;
    width     = 0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (lcd_e && !e_prev) begin
        cur_data = lcd_data;
        cur_rs   = lcd_rs;
        width    = 1;
        q_rise.push_back(cyc);
        if ((prev_data !== lcd_data) || (prev_rs !== lcd_rs)) stab_err = stab_err + 1;
      end else if (lcd_e) begin
        width = width + 1;
        if ((cur_data !== lcd_data) || (cur_rs !== lcd_rs)) stab_err = stab_err + 1;
      end else if (e_prev) begin
        q_data.push_back(cur_data);
        q_rs.push_back(cur_rs);
        q_width.push_back(width);
        q_fall.push_back(cyc);
        if (rst_n && ((cur_data !== lcd_data) || (cur_rs !== lcd_rs))) stab_err = stab_err + 1;
      end
      if (ack_lcd) begin
        ack_count = ack_count + 1;
        if (ack_prev) ack_long = ack_long + 1;
      end
      e_prev    = lcd_e;
      ack_prev  = ack_lcd;
      prev_data = lcd_data;
      prev_rs   = lcd_rs;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rq, input logic row, input logic [5:0] col,
                               input logic [7:0] ch);
    rq_lcd     = rq;
    lcd_row    = row;
    lcd_column = col;
    lcd_char   = ch;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts = n_asserts + 1;
    assert (observed === expected) else begin
      n_fail = n_fail + 1;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPulse(input int idx, input logic [7:0] data, input logic rs);
    if (idx < q_data.size()) begin
      checkOutput($sformatf("pulse%0d_data", idx), 32'(q_data[idx]), 32'(data));
      checkOutput($sformatf("pulse%0d_rs", idx), 32'(q_rs[idx]), 32'(rs));
      checkOutput($sformatf("pulse%0d_width", idx), 32'(q_width[idx]), 32'(P_EW));
    end else begin
      checkOutput($sformatf("pulse%0d_present", idx), 32'(q_data.size()), 32'(idx + 1));
    end
  endtask

  task automatic waitAck(input int target, input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (ack_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitInit(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (init_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic ok;
    int   c_rel;
    int   t_done;
    int   t_ack;
    int   t0;
    int   base;
    int   acks_before;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    repeat (3) tick();

    // Everything idle while reset is held.
    checkOutput("rst_lcd_e", 32'(lcd_e), 32'(0));
    checkOutput("rst_lcd_rs", 32'(lcd_rs), 32'(0));
    checkOutput("rst_lcd_rw", 32'(lcd_rw), 32'(0));
    checkOutput("rst_lcd_data", 32'(lcd_data), 32'(0));
    checkOutput("rst_ack", 32'(ack_lcd), 32'(0));
    checkOutput("rst_init_done", 32'(init_done), 32'(0));

    // A request raised before init completes must wait for init.
    applyStimulus(1'b1, 1'b0, 6'd1, 8'h4C);
    rst_n = 1'b1;
    c_rel = cyc;
    $display("[TB] reset released, power-on wait running");
    repeat (P_PWR) tick();
    checkOutput("pwr_no_pulse", 32'(q_rise.size()), 32'(0));
    checkOutput("pwr_init_done_low", 32'(init_done), 32'(0));

    waitInit(400, ok);
    checkOutput("init_done_seen", 32'(ok), 32'(1));
    t_done = cyc;
    checkOutput("init_pulse_count", 32'(q_data.size()), 32'(4));
    for (int i = 0; i < 4; i++) checkPulse(i, init_bytes[i], 1'b0);
    if (q_rise.size() >= 4) begin
      checkOutput("first_e_rise", 32'(q_rise[0] - c_rel), 32'(P_PWR + P_AS));
      checkOutput("gap_after_38", 32'(q_rise[1] - q_fall[0]), 32'(P_H + P_EXEC + P_AS));
      checkOutput("gap_after_clear", 32'(q_rise[3] - q_fall[2]), 32'(P_H + P_CLR + P_AS));
      checkOutput("init_done_delay", 32'(t_done - q_fall[3]), 32'(P_H + P_EXEC));
    end

    // Pending request: row 0, column 1, 'L'.
    waitAck(1, 200, ok);
    t_ack = cyc;
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    checkOutput("req1_ack_seen", 32'(ok), 32'(1));
    checkPulse(4, 8'h81, 1'b0);
    checkPulse(5, 8'h4C, 1'b1);
    if (q_fall.size() >= 6)
      checkOutput("req1_ack_delay", 32'(t_ack - q_fall[5]), 32'(P_H + P_EXEC));
    tick();
    checkOutput("req1_ack_single", 32'(ack_lcd), 32'(0));
    checkOutput("req1_ack_count", 32'(ack_count), 32'(1));

    // Row 1, column 6; request dropped mid-transfer must still complete.
    tick();
    applyStimulus(1'b1, 1'b1, 6'd6, 8'h6E);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    waitAck(2, 200, ok);
    checkOutput("req2_ack_seen", 32'(ok), 32'(1));
    checkPulse(6, 8'hC6, 1'b0);
    checkPulse(7, 8'h6E, 1'b1);
    checkOutput("req2_pulse_count", 32'(q_data.size()), 32'(8));

    // Column 45 is out of range: ack without any bus activity.
    repeat (2) tick();
    base = q_rise.size();
    applyStimulus(1'b1, 1'b0, 6'd45, 8'h33);
    t0 = cyc;
    waitAck(3, 4, ok);
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    checkOutput("oor_ack_seen", 32'(ok), 32'(1));
    checkOutput("oor_ack_latency", 32'(cyc - t0), 32'(1));
    repeat (5) tick();
    checkOutput("oor_no_pulse", 32'(q_rise.size()), 32'(base));
    checkOutput("oor_ack_count", 32'(ack_count), 32'(3));

    // Back-to-back: rq held high across the first ack; second request uses
    // the last valid column on the bottom row.
    applyStimulus(1'b1, 1'b0, 6'd0, 8'h41);
    waitAck(4, 200, ok);
    checkOutput("b2b_first_ack", 32'(ok), 32'(1));
    applyStimulus(1'b1, 1'b1, 6'd39, 8'h42);
    waitAck(5, 200, ok);
    checkOutput("b2b_second_ack", 32'(ok), 32'(1));
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    repeat (30) tick();
    checkOutput("b2b_ack_count", 32'(ack_count), 32'(5));
    checkOutput("b2b_pulse_count", 32'(q_data.size()), 32'(12));
    checkPulse(8, 8'h80, 1'b0);
    checkPulse(9, 8'h41, 1'b1);
    checkPulse(10, 8'hE7, 1'b0);
    checkPulse(11, 8'h42, 1'b1);

    // Reset asserted while E is high for a data byte.
    applyStimulus(1'b1, 1'b0, 6'd2, 8'h55);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (lcd_e && lcd_rs) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("abort_enable_seen", 32'(ok), 32'(1));
    acks_before = ack_count;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_e_low", 32'(lcd_e), 32'(0));
    checkOutput("abort_init_done_low", 32'(init_done), 32'(0));
    checkOutput("abort_data_clear", 32'(lcd_data), 32'(0));
    checkOutput("abort_rs_clear", 32'(lcd_rs), 32'(0));
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    c_rel = cyc;
    base  = q_rise.size();
    waitInit(400, ok);
    checkOutput("reinit_done_seen", 32'(ok), 32'(1));
    checkOutput("reinit_pulse_count", 32'(q_data.size()), 32'(base + 4));
    for (int i = 0; i < 4; i++) checkPulse(base + i, init_bytes[i], 1'b0);
    if (q_rise.size() > base)
      checkOutput("reinit_first_rise", 32'(q_rise[base] - c_rel), 32'(P_PWR + P_AS));
    checkOutput("abort_no_ack", 32'(ack_count), 32'(acks_before));

    checkOutput("ack_never_long", 32'(ack_long), 32'(0));
    checkOutput("bus_stable", 32'(stab_err), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
